// File: rtl/si53xx_spi_responder.sv
// SPI mode-0 register responder modelled on the Si53xx command set. The SPI pins are
// oversampled by clk, and a 256-byte register file can also be preloaded from the local side.
module si53xx_spi_responder (
  input  logic       clk,
  input  logic       reset,
  input  logic       nCS,
  input  logic       sclk,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic       ld_en,
  input  logic [7:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] cur_addr,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CMD    = 2'd1,
    ST_ARG    = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_SETADDR = 3'd0,
    OP_WR      = 3'd1,
    OP_WRINC   = 3'd2,
    OP_RD      = 3'd3,
    OP_RDINC   = 3'd4
  } op_t;

  state_t      state_r, state_nx_s;
  op_t         op_r, op_dec_s;
  logic        op_ok_s;

  logic        ncs_meta_r, ncs_sync_r, ncs_prev_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic        sdi_meta_r, sdi_sync_r;

  logic [2:0]  bit_cnt_r;
  logic [6:0]  shift_in_r;
  logic [7:0]  tx_r;
  logic        sdo_oe_r;
  logic [7:0]  cur_addr_r, wr_addr_r, wr_data_r;
  logic        wr_strobe_r, cmd_err_r;
  logic [7:0]  mem_r [0:255];

  logic        sclk_rise_s, sclk_fall_s, ncs_rise_s, ncs_fall_s;
  logic        active_s, byte_done_s, spi_wr_s, op_is_rd_s;
  logic [7:0]  rx_byte_s, addr_inc_s;

  // Two-flop synchronizers plus one history flop for edge detection.
  // nCS resets low so a select already held low at release is not seen as a fall.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ncs_meta_r  <= 1'b0;
      ncs_sync_r  <= 1'b0;
      ncs_prev_r  <= 1'b0;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      sdi_meta_r  <= 1'b0;
      sdi_sync_r  <= 1'b0;
    end else begin
      ncs_meta_r  <= nCS;
      ncs_sync_r  <= ncs_meta_r;
      ncs_prev_r  <= ncs_sync_r;
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      sdi_meta_r  <= sdi;
      sdi_sync_r  <= sdi_meta_r;
    end
  end

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign ncs_rise_s  = ncs_sync_r & ~ncs_prev_r;
  assign ncs_fall_s  = ~ncs_sync_r & ncs_prev_r;
  assign addr_inc_s  = cur_addr_r + 8'd1;
  // The eighth bit joins the seven already shifted in to form the completed byte.
  assign rx_byte_s   = {shift_in_r, sdi_sync_r};

  // Byte-level qualifiers derived from the current state.
  always_comb begin
    active_s    = 1'b0;
    byte_done_s = 1'b0;
    spi_wr_s    = 1'b0;
    op_is_rd_s  = 1'b0;
    if ((state_r == ST_CMD) || (state_r == ST_ARG)) begin
      active_s = 1'b1;
    end else begin
      active_s = 1'b0;
    end
    if (active_s && sclk_rise_s && (bit_cnt_r == 3'd7) && !ncs_rise_s) begin
      byte_done_s = 1'b1;
    end else begin
      byte_done_s = 1'b0;
    end
    if ((op_r == OP_RD) || (op_r == OP_RDINC)) begin
      op_is_rd_s = 1'b1;
    end else begin
      op_is_rd_s = 1'b0;
    end
    if (byte_done_s && (state_r == ST_ARG) && ((op_r == OP_WR) || (op_r == OP_WRINC))) begin
      spi_wr_s = 1'b1;
    end else begin
      spi_wr_s = 1'b0;
    end
  end

  // Command byte decode.
  always_comb begin
    op_dec_s = OP_SETADDR;
    op_ok_s  = 1'b0;
    case (rx_byte_s)
      8'h00: begin op_dec_s = OP_SETADDR; op_ok_s = 1'b1; end
      8'h40: begin op_dec_s = OP_WR;      op_ok_s = 1'b1; end
      8'h60: begin op_dec_s = OP_WRINC;   op_ok_s = 1'b1; end
      8'h80: begin op_dec_s = OP_RD;      op_ok_s = 1'b1; end
      8'hA0: begin op_dec_s = OP_RDINC;   op_ok_s = 1'b1; end
      default: begin op_dec_s = OP_SETADDR; op_ok_s = 1'b0; end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic; a deselect overrides everything.
  always_comb begin
    state_nx_s = state_r;
    if (ncs_rise_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (ncs_fall_s) begin
            state_nx_s = ST_CMD;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_CMD: begin
          if (byte_done_s) begin
            if (op_ok_s) begin
              state_nx_s = ST_ARG;
            end else begin
              state_nx_s = ST_IGNORE;
            end
          end else begin
            state_nx_s = ST_CMD;
          end
        end
        ST_ARG:    state_nx_s = ST_ARG;
        ST_IGNORE: state_nx_s = ST_IGNORE;
        default:   state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Serial datapath, address pointer, write reporting and read shifter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_r        <= OP_SETADDR;
      bit_cnt_r   <= 3'd0;
      shift_in_r  <= 7'd0;
      tx_r        <= 8'd0;
      sdo_oe_r    <= 1'b0;
      cur_addr_r  <= 8'd0;
      wr_addr_r   <= 8'd0;
      wr_data_r   <= 8'd0;
      wr_strobe_r <= 1'b0;
      cmd_err_r   <= 1'b0;
    end else begin
      wr_strobe_r <= 1'b0;
      if (ncs_rise_s) begin
        bit_cnt_r  <= 3'd0;
        shift_in_r <= 7'd0;
        tx_r       <= 8'd0;
        sdo_oe_r   <= 1'b0;
      end else if ((state_r == ST_IDLE) && ncs_fall_s) begin
        bit_cnt_r  <= 3'd0;
        shift_in_r <= 7'd0;
      end else if (active_s) begin
        if (sclk_rise_s) begin
          bit_cnt_r  <= bit_cnt_r + 3'd1;
          shift_in_r <= rx_byte_s[6:0];
        end
        if (byte_done_s && (state_r == ST_CMD)) begin
          if (op_ok_s) begin
            op_r <= op_dec_s;
            if ((op_dec_s == OP_RD) || (op_dec_s == OP_RDINC)) begin
              tx_r     <= mem_r[cur_addr_r];
              sdo_oe_r <= 1'b1;
            end
          end else begin
            cmd_err_r <= 1'b1;
          end
        end else if (byte_done_s) begin
          case (op_r)
            OP_SETADDR: cur_addr_r <= rx_byte_s;
            OP_WR: begin
              wr_strobe_r <= 1'b1;
              wr_addr_r   <= cur_addr_r;
              wr_data_r   <= rx_byte_s;
            end
            OP_WRINC: begin
              wr_strobe_r <= 1'b1;
              wr_addr_r   <= cur_addr_r;
              wr_data_r   <= rx_byte_s;
              cur_addr_r  <= addr_inc_s;
            end
            OP_RD:    tx_r <= mem_r[cur_addr_r];
            OP_RDINC: begin
              cur_addr_r <= addr_inc_s;
              tx_r       <= mem_r[addr_inc_s];
            end
            default: cur_addr_r <= cur_addr_r;
          endcase
        end else if (sclk_fall_s && (state_r == ST_ARG) && op_is_rd_s && (bit_cnt_r != 3'd0)) begin
          // No shift on the fall that follows a byte boundary: the new MSB must survive it.
          tx_r <= {tx_r[6:0], 1'b0};
        end
      end
    end
  end

  // Register file; the SPI write is placed last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else begin
      if (ld_en) begin
        mem_r[ld_addr] <= ld_data;
      end
      if (spi_wr_s) begin
        mem_r[cur_addr_r] <= rx_byte_s;
      end
    end
  end

  assign sdo       = tx_r[7];
  assign sdo_oe    = sdo_oe_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign cur_addr  = cur_addr_r;
  assign cmd_err   = cmd_err_r;

endmodule
